stage_if: RTL and testbench

//   Instruction-fetch stage: owns the PC and fetches instructions from a variable-latency ROM.

---
 rtl/stage_if_pkg.sv | 18 +
 rtl/stage_if_if.sv | 21 ++
 rtl/stage_if_pc_reg.sv | 40 ++++
 rtl/stage_if.sv | 143 ++++++++++++++
 tb/tb_stage_if.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_if_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package stage_if_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } if_state_e;

  localparam logic [31:0] INST_NOP  = 32'h0000_0000;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Instruction addresses are word aligned; redirect targets drop their low bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/stage_if_if.sv
// Instruction ROM request/response bus between the fetch stage and the ROM.
interface stage_if_if;
  logic        rom_read_enable;
  logic [31:0] rom_address;
  logic [31:0] rom_data;
  logic        rom_ready;

  modport master (
    output rom_read_enable,
    output rom_address,
    input  rom_data,
    input  rom_ready
  );

  modport slave (
    input  rom_read_enable,
    input  rom_address,
    output rom_data,
    output rom_ready
  );
endinterface

// File: rtl/stage_if_pc_reg.sv
// Program counter: load (redirect) beats increment (capture) beats hold.
module stage_if_pc_reg
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = align_word(load_data_i);
    end else if (inc_i) begin
      pc_d = pc_q + PC_STEP;
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: issues ROM requests from the PC, buffers one response
// under stall, and squashes the outstanding fetch when stage_id redirects.
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              pc_write_enable,
  input  logic [31:0]       pc_write_data,
  stage_if_if.master        rom,
  output logic [31:0]       pc_read_data,
  output logic [31:0]       instruction_o,
  output logic              valid_o,
  output logic              stall_request
);

  if_state_e   state_q, state_d;
  logic        squash_q, squash_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        pc_load;
  logic        pc_inc;
  logic [31:0] pc_cur;
  logic        req_active;

  stage_if_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk         (clk),
    .reset       (reset),
    .load_i      (pc_load),
    .load_data_i (pc_write_data),
    .inc_i       (pc_inc),
    .pc_o        (pc_cur)
  );

  // A request is live in S_REQ/S_WAIT; a full skid entry blocks further fetches.
  assign req_active = (state_q != S_HOLD) && !skid_valid_q;

  always_comb begin
    state_d      = state_q;
    squash_d     = squash_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    req_addr_d   = req_addr_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_inst_d   = out_inst_q;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    if (pc_write_enable) begin
      pc_load      = 1'b1;
      skid_valid_d = 1'b0;
      out_valid_d  = stall ? out_valid_q : 1'b0;
      // An unanswered request must stay on the bus, so its answer is discarded later.
      if (req_active && !rom.rom_ready) begin
        state_d    = S_WAIT;
        squash_d   = 1'b1;
        req_addr_d = (state_q == S_REQ) ? pc_cur : req_addr_q;
      end else begin
        state_d  = S_REQ;
        squash_d = 1'b0;
      end
    end else if (req_active) begin
      if (rom.rom_ready) begin
        state_d  = S_REQ;
        squash_d = 1'b0;
        if (squash_q) begin
          out_valid_d = stall ? out_valid_q : 1'b0;
        end else if (stall) begin
          pc_inc       = 1'b1;
          skid_valid_d = 1'b1;
          skid_pc_d    = pc_cur;
          skid_inst_d  = rom.rom_data;
          state_d      = S_HOLD;
        end else begin
          pc_inc      = 1'b1;
          out_valid_d = 1'b1;
          out_pc_d    = pc_cur;
          out_inst_d  = rom.rom_data;
        end
      end else begin
        state_d     = S_WAIT;
        req_addr_d  = (state_q == S_REQ) ? pc_cur : req_addr_q;
        out_valid_d = stall ? out_valid_q : 1'b0;
      end
    end else if (stall) begin
      state_d = S_HOLD;
    end else begin
      out_valid_d  = 1'b1;
      out_pc_d     = skid_pc_q;
      out_inst_d   = skid_inst_q;
      skid_valid_d = 1'b0;
      state_d      = S_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      squash_q     <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= ZERO_WORD;
      skid_inst_q  <= INST_NOP;
      req_addr_q   <= ZERO_WORD;
      out_valid_q  <= 1'b0;
      out_pc_q     <= ZERO_WORD;
      out_inst_q   <= INST_NOP;
    end else begin
      state_q      <= state_d;
      squash_q     <= squash_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      req_addr_q   <= req_addr_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_inst_q   <= out_inst_d;
    end
  end

  // While squashing, the bus keeps the old address even though the PC already holds the target.
  assign rom.rom_read_enable = !reset && req_active;
  assign rom.rom_address     = reset ? ZERO_WORD :
                               ((state_q == S_WAIT) ? req_addr_q : pc_cur);

  assign valid_o       = !reset && out_valid_q;
  assign pc_read_data  = reset ? ZERO_WORD : out_pc_q;
  assign instruction_o = reset ? INST_NOP : out_inst_q;
  assign stall_request = !reset && !out_valid_q;

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: vector table, directed multi-cycle sequences, and random
// stimulus checked against an instruction-stream model of the fetch stage.
module tb_stage_if;
  import stage_if_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, we;
  logic [31:0] wdata;
  logic [31:0] pc_rd, inst;
  logic        valid, sreq;

  always #5 clk = ~clk;

  stage_if_if rif ();

  stage_if dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .pc_write_enable (we),
    .pc_write_data   (wdata),
    .rom             (rif),
    .pc_read_data    (pc_rd),
    .instruction_o   (inst),
    .valid_o         (valid),
    .stall_request   (sreq)
  );

  // ROM: answers lat cycles after a request starts, data = address + 0x100.
  int          lat_min = 0, lat_max = 0, lat = 0, cnt = 0;
  logic        manual = 1'b0, man_ready = 1'b0;
  logic [31:0] man_data = 32'h0;
  logic        auto_rdy;
  assign auto_rdy      = rif.rom_read_enable && (cnt == lat);
  assign rif.rom_ready = manual ? man_ready : auto_rdy;
  assign rif.rom_data  = manual ? man_data :
                         (auto_rdy ? rif.rom_address + 32'h100 : 32'hDEAD_BEEF);

  always @(posedge clk) begin
    if (!rif.rom_read_enable || rif.rom_ready) begin
      cnt <= 0;
      lat <= int'($urandom_range(lat_max, lat_min));
    end else begin
      cnt <= cnt + 1;
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: the stream ID consumes must be consecutive words from the
  // latest redirect target (or RESET_PC), each with instruction = pc + 0x100.
  logic [31:0] exp_next = 32'h0;
  logic        drop_held = 1'b0;
  int          delivered = 0;
  logic        p_reset = 1'b1, p_stall = 1'b0, p_valid = 1'b0, p_en = 1'b0, p_ready = 1'b0;
  logic [31:0] p_pc = 32'h0, p_inst = 32'h0, p_addr = 32'h0;

  task automatic monitor();
    chk("stall_request", 32'(sreq), 32'(!reset && !valid));
    if (reset) begin
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_pc", pc_rd, 32'h0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_rom_en", 32'(rif.rom_read_enable), 32'h0);
      chk("rst_rom_addr", rif.rom_address, 32'h0);
      exp_next  = 32'h0;
      drop_held = 1'b0;
    end else begin
      if (!p_reset && p_stall) begin
        chk("freeze_valid", 32'(valid), 32'(p_valid));
        chk("freeze_pc", pc_rd, p_pc);
        chk("freeze_inst", inst, p_inst);
      end
      if (!p_reset && p_en && !p_ready) begin
        chk("req_held", 32'(rif.rom_read_enable), 32'h1);
        chk("addr_stable", rif.rom_address, p_addr);
      end
      if (we) begin
        exp_next  = wdata & 32'hFFFF_FFFC;
        drop_held = stall;
      end else if (!stall) begin
        if (valid && !drop_held) begin
          chk("stream_pc", pc_rd, exp_next);
          chk("stream_inst", inst, exp_next + 32'h100);
          exp_next = exp_next + 32'd4;
          delivered++;
        end
        drop_held = 1'b0;
      end
    end
    p_reset = reset; p_stall = stall; p_valid = valid; p_pc = pc_rd; p_inst = inst;
    p_en = rif.rom_read_enable; p_ready = rif.rom_ready; p_addr = rif.rom_address;
  endtask

  task automatic at_neg();
    @(negedge clk);
    monitor();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    at_neg();
    to_pos();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; stall = 1'b0; we = 1'b0; wdata = 32'h0;
    for (int k = 0; k < n; k++) cyc();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      at_neg();
      if (valid) begin
        seen = 1'b1;
        chk({name, "_pc"}, pc_rd, exp_pc);
        chk({name, "_inst"}, inst, exp_pc + 32'h100);
      end
      to_pos();
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no valid_o within %0d cycles, expected pc %h", name, budget, exp_pc);
    end
  endtask

  typedef struct {
    logic        rst, stl, wen;
    logic [31:0] wd;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc, ins;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic stl, input logic wen,
                              input logic [31:0] wd, input logic en, input logic [31:0] addr,
                              input logic vld, input logic [31:0] pc, input logic [31:0] ins);
    vec_t v;
    v.rst = rst; v.stl = stl; v.wen = wen; v.wd = wd; v.en = en;
    v.addr = addr; v.vld = vld; v.pc = pc; v.ins = ins;
    return v;
  endfunction

  vec_t vec [19];

  initial begin
    // 0-wait ROM: sequential fetch, stall+skid, redirects (unaligned, with stall, wrap), reset.
    vec[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'h0);
    vec[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         32'h0);
    vec[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0,         32'h100);
    vec[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h4,         32'h104);
    vec[4]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         1'b1, 32'h8,         32'h108);
    vec[5]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8,         32'h108);
    vec[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8,         32'h108);
    vec[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h10,        1'b1, 32'hC,         32'h10C);
    vec[8]  = mk(1'b0, 1'b0, 1'b1, 32'h43,        1'b1, 32'h14,        1'b1, 32'h10,        32'h110);
    vec[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h40,        1'b0, 32'h0,         32'h0);
    vec[10] = mk(1'b0, 1'b1, 1'b1, 32'h80,        1'b1, 32'h44,        1'b1, 32'h40,        32'h140);
    vec[11] = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h80,        1'b1, 32'h40,        32'h140);
    vec[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40,        32'h140);
    vec[13] = mk(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h84,        1'b1, 32'h80,        32'h180);
    vec[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'h0);
    vec[15] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0000_00FC);
    vec[16] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'h0);
    vec[17] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         32'h0);
    vec[18] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0,         32'h100);

    do_reset(1);
    for (int i = 0; i < 19; i++) begin
      reset = vec[i].rst; stall = vec[i].stl; we = vec[i].wen; wdata = vec[i].wd;
      at_neg();
      chk($sformatf("t%0d_valid", i), 32'(valid), 32'(vec[i].vld));
      chk($sformatf("t%0d_sreq", i), 32'(sreq), 32'(!vec[i].rst && !vec[i].vld));
      chk($sformatf("t%0d_en", i), 32'(rif.rom_read_enable), 32'(vec[i].en));
      if (vec[i].en || vec[i].rst) chk($sformatf("t%0d_addr", i), rif.rom_address, vec[i].addr);
      if (vec[i].vld || vec[i].rst) begin
        chk($sformatf("t%0d_pc", i), pc_rd, vec[i].pc);
        chk($sformatf("t%0d_inst", i), inst, vec[i].ins);
      end
      to_pos();
    end

    // 3-cycle ROM: address held, valid every 4 cycles, then redirect while waiting on addr 8.
    lat_min = 3; lat_max = 3;
    do_reset(2);
    for (int c = 1; c <= 9; c++) begin
      at_neg();
      chk($sformatf("lat3_valid_c%0d", c), 32'(valid), 32'(c == 5 || c == 9));
      if (c <= 3) chk($sformatf("lat3_addr_c%0d", c), rif.rom_address, 32'h0);
      to_pos();
    end
    we = 1'b1; wdata = 32'h40;
    at_neg();
    chk("wait_addr8", rif.rom_address, 32'h8);
    to_pos();
    we = 1'b0;
    wait_valid("redirect_wait", 32'h40, 12);

    // Stall for 5 cycles with the response landing in the skid.
    lat_min = 2; lat_max = 2;
    do_reset(2);
    cyc(); cyc(); cyc();
    stall = 1'b1;
    for (int c = 4; c <= 9; c++) begin
      if (c == 9) stall = 1'b0;
      at_neg();
      chk($sformatf("stall_pc_c%0d", c), pc_rd, 32'h0);
      chk($sformatf("stall_valid_c%0d", c), 32'(valid), 32'h1);
      if (c == 7 || c == 8) chk($sformatf("hold_no_req_c%0d", c), 32'(rif.rom_read_enable), 32'h0);
      to_pos();
    end
    at_neg();
    chk("skid_pc", pc_rd, 32'h4);
    chk("skid_inst", inst, 32'h104);
    to_pos();
    wait_valid("after_skid", 32'h8, 8);

    // Reset while waiting, stale response during reset, clean restart.
    lat_min = 3; lat_max = 3;
    do_reset(2);
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    manual = 1'b1; man_ready = 1'b1; man_data = 32'hBAD0_BAD0;
    cyc();
    reset = 1'b0; manual = 1'b0; man_ready = 1'b0;
    at_neg();
    chk("post_rst_valid", 32'(valid), 32'h0);
    chk("post_rst_en", 32'(rif.rom_read_enable), 32'h1);
    chk("post_rst_addr", rif.rom_address, 32'h0);
    to_pos();
    wait_valid("post_rst", 32'h0, 8);

    // Random traffic against the stream model.
    lat_min = 0; lat_max = 3;
    do_reset(2);
    begin
      int start = delivered;
      for (int n = 0; n < 3000; n++) begin
        reset = ($urandom_range(0, 499) == 0);
        stall = ($urandom_range(0, 3) == 0);
        we    = ($urandom_range(0, 15) == 0);
        wdata = ($urandom_range(0, 1) == 1) ? $urandom : (32'hFFFF_FFF0 | ($urandom & 32'hF));
        cyc();
      end
      chk("random_progress", 32'(delivered - start > 100), 32'h1);
    end
    reset = 1'b0; stall = 1'b0; we = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
